// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: opcode constants and helpers used
// by both the register file and the decode pipeline register.
package decode_stage_pkg;

  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LW   = 6'h23;

  // Register-address width for a given register count.
  function automatic int addr_width(input int nregs);
    return (nregs <= 2) ? 1 : $clog2(nregs);
  endfunction

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/decode_stage_regfile_2r1w.sv
// Two asynchronous read ports, one synchronous write port, register 0 hardwired
// to zero, and write-through so a same-cycle write is visible on the reads.
module regfile_2r1w
  import decode_stage_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int NREGS  = 32,
  localparam int AW     = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr1,
  input  logic [AW-1:0]     raddr2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
);

  logic [DATA_W-1:0] mem_q [NREGS];
  logic [DATA_W-1:0] mem_d [NREGS];

  always_comb begin
    mem_d = mem_q;
    if (we && (waddr != '0) && (int'(waddr) < NREGS)) begin
      mem_d[waddr] = wdata;
    end
  end

  // NOTE: the whole array is cleared by reset because the stage must read
  // zero from every register after reset, so this cannot map to plain SRAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values.
      mem_q <= mem_d;
    end
  end

  // NOTE: each comb output gets a default first so no path infers a latch.
  always_comb begin
    rdata1 = '0;
    if ((raddr1 != '0) && (int'(raddr1) < NREGS)) begin
      rdata1 = (we && (waddr == raddr1)) ? wdata : mem_q[raddr1];
    end
  end

  always_comb begin
    rdata2 = '0;
    if ((raddr2 != '0) && (int'(raddr2) < NREGS)) begin
      rdata2 = (we && (waddr == raddr2)) ? wdata : mem_q[raddr2];
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: register read, immediate extension, load-use stall and a
// single valid/ready output register with held-operand refresh.
module decode_stage
  import decode_stage_pkg::*;
#(
  parameter  int DATA_W    = 32,
  parameter  int NREGS     = 32,
  parameter  bit HAZARD_EN = 1'b1,
  localparam int AW        = addr_width(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic              wb_en,
  input  logic [AW-1:0]     wb_reg,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_memread,
  input  logic [AW-1:0]     ex_rt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [5:0]        opcode,
  output logic [AW-1:0]     rs,
  output logic [AW-1:0]     rt,
  output logic [AW-1:0]     rd,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic [DATA_W-1:0] imm_ext,
  output logic              stall
);

  typedef struct packed {
    logic [5:0]        opcode;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic [AW-1:0]     rd;
    logic [DATA_W-1:0] rdata1;
    logic [DATA_W-1:0] rdata2;
    logic [DATA_W-1:0] imm;
  } dec_t;

  logic [5:0]        in_op;
  logic [AW-1:0]     in_rs, in_rt, in_rd;
  logic signed [15:0] in_imm16;
  logic [DATA_W-1:0] in_imm;
  logic [DATA_W-1:0] rf_rdata1, rf_rdata2;
  logic              hazard, accept;

  dec_t dec_q, dec_d;
  logic valid_q, valid_d;

  assign in_op    = instr[31:26];
  assign in_rs    = instr[21 +: AW];
  assign in_rt    = instr[16 +: AW];
  assign in_rd    = instr[11 +: AW];
  assign in_imm16 = instr[15:0];

  always_comb begin
    in_imm = is_zero_ext(in_op) ? DATA_W'(instr[15:0]) : DATA_W'(in_imm16);
  end

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS)
  ) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (wb_en),
    .waddr  (wb_reg),
    .wdata  (wb_data),
    .raddr1 (in_rs),
    .raddr2 (in_rt),
    .rdata1 (rf_rdata1),
    .rdata2 (rf_rdata2)
  );

  always_comb begin
    hazard = HAZARD_EN && in_valid && ex_memread && (ex_rt != '0) &&
             ((ex_rt == in_rs) || (ex_rt == in_rt));
  end

  assign in_ready = !hazard && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  // Held low during reset even if the EX-side inputs are not yet quiet.
  assign stall    = hazard && rst_n;

  always_comb begin
    dec_d   = dec_q;
    valid_d = valid_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d       = 1'b1;
      dec_d.opcode  = in_op;
      dec_d.rs      = in_rs;
      dec_d.rt      = in_rt;
      dec_d.rd      = in_rd;
      dec_d.rdata1  = rf_rdata1;
      dec_d.rdata2  = rf_rdata2;
      dec_d.imm     = in_imm;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else if (valid_q && wb_en && (wb_reg != '0)) begin
      // Stalled output must not go stale against a late writeback.
      if (wb_reg == dec_q.rs) dec_d.rdata1 = wb_data;
      if (wb_reg == dec_q.rt) dec_d.rdata2 = wb_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dec_q   <= '0;
    end else begin
      valid_q <= valid_d;
      dec_q   <= dec_d;
    end
  end

  assign out_valid  = valid_q;
  assign opcode     = dec_q.opcode;
  assign rs         = dec_q.rs;
  assign rt         = dec_q.rt;
  assign rd         = dec_q.rd;
  assign read_data1 = dec_q.rdata1;
  assign read_data2 = dec_q.rdata2;
  assign imm_ext    = dec_q.imm;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus a randomized
// run compared against a cycle-level behavioural model.
module tb_decode_stage;

  localparam int DATA_W = 32;
  localparam int NREGS  = 32;
  localparam int AW     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid, in_ready;
  logic [31:0]       instr;
  logic              wb_en;
  logic [AW-1:0]     wb_reg;
  logic [DATA_W-1:0] wb_data;
  logic              ex_memread;
  logic [AW-1:0]     ex_rt;
  logic              flush;
  logic              out_valid, out_ready;
  logic [5:0]        opcode;
  logic [AW-1:0]     rs, rt, rd;
  logic [DATA_W-1:0] read_data1, read_data2, imm_ext;
  logic              stall;

  always #5 clk = ~clk;

  decode_stage #(.DATA_W(DATA_W), .NREGS(NREGS), .HAZARD_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .wb_en(wb_en), .wb_reg(wb_reg), .wb_data(wb_data),
    .ex_memread(ex_memread), .ex_rt(ex_rt), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .read_data1(read_data1),
    .read_data2(read_data2), .imm_ext(imm_ext), .stall(stall)
  );

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [31:0] m_regs [NREGS];
  bit          m_valid;
  logic [5:0]  m_op;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic [31:0] m_rd1, m_rd2, m_imm;

  function automatic logic [31:0] mk_r(int r_s, int r_t, int r_d);
    return {6'h00, 5'(r_s), 5'(r_t), 5'(r_d), 5'h00, 6'h20};
  endfunction

  function automatic logic [31:0] mk_i(logic [5:0] op, int r_s, int r_t, logic [15:0] imm);
    return {op, 5'(r_s), 5'(r_t), imm};
  endfunction

  function automatic bit exp_hazard();
    return in_valid && ex_memread && (ex_rt != 0) &&
           ((ex_rt == instr[25:21]) || (ex_rt == instr[20:16]));
  endfunction

  function automatic bit exp_ready();
    return !exp_hazard() && (!m_valid || out_ready);
  endfunction

  function automatic logic [31:0] reg_val(logic [4:0] r);
    if (r == 0) return 32'h0;
    if (wb_en && wb_reg == r) return wb_data;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    m_valid = 0; m_op = 0; m_rs = 0; m_rt = 0; m_rd = 0;
    m_rd1 = 0; m_rd2 = 0; m_imm = 0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 32'h0;
  endtask

  task automatic idle();
    in_valid = 0; instr = 0; wb_en = 0; wb_reg = 0; wb_data = 0;
    ex_memread = 0; ex_rt = 0; flush = 0; out_ready = 1;
  endtask

  // Advance one clock, updating the model from the inputs applied this cycle.
  task automatic tick();
    bit acc;
    logic [15:0] imm;
    acc = in_valid && exp_ready() && !flush;
    imm = instr[15:0];
    if (flush) begin
      m_valid = 0;
    end else if (acc) begin
      m_valid = 1;
      m_op = instr[31:26]; m_rs = instr[25:21]; m_rt = instr[20:16]; m_rd = instr[15:11];
      m_rd1 = reg_val(m_rs);
      m_rd2 = reg_val(m_rt);
      if (m_op == 6'h0C || m_op == 6'h0D || m_op == 6'h0E) m_imm = {16'h0000, imm};
      else m_imm = {{16{imm[15]}}, imm};
    end else if (out_ready) begin
      m_valid = 0;
    end else if (m_valid && wb_en && wb_reg != 0) begin
      if (wb_reg == m_rs) m_rd1 = wb_data;
      if (wb_reg == m_rt) m_rd2 = wb_data;
    end
    if (wb_en && wb_reg != 0) m_regs[wb_reg] = wb_data;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    in_valid = 1; instr = mk_r(1, 3, 2); ex_memread = 1; ex_rt = 3;
    #2;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %0b want 0", out_valid); end
    n_vec++;
    if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_vec++;
    if ({opcode, rs, rt, rd, read_data1, read_data2, imm_ext} !== '0) begin
      n_err++;
      $display("FAIL reset_fields: got op=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h want all 0",
               opcode, rs, rt, rd, read_data1, read_data2, imm_ext);
    end
    idle();
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_release_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_read_r5();
    idle();
    wb_en = 1; wb_reg = 5; wb_data = 32'h0000_1234;
    tick();
    idle();
    in_valid = 1; instr = mk_r(5, 0, 9);
    #1;
    n_vec++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL r5_in_ready: got %0b want 1", in_ready); end
    tick();
    in_valid = 0;
    n_vec++;
    if (out_valid !== 1'b1) begin n_err++; $display("FAIL r5_valid: got %0b want 1", out_valid); end
    n_vec++;
    if (read_data1 !== 32'h0000_1234 || read_data2 !== 32'h0) begin
      n_err++; $display("FAIL r5_data: got %h/%h want 00001234/00000000", read_data1, read_data2);
    end
    n_vec++;
    if (rs !== 5'd5 || rt !== 5'd0 || rd !== 5'd9) begin
      n_err++; $display("FAIL r5_fields: got rs=%0d rt=%0d rd=%0d want 5/0/9", rs, rt, rd);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL r5_drain: got %0b want 0", out_valid); end
  endtask

  task automatic test_bypass();
    idle();
    in_valid = 1; instr = mk_r(7, 0, 1);
    wb_en = 1; wb_reg = 7; wb_data = 32'hDEAD_BEEF;
    tick();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || read_data1 !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL bypass: got valid=%0b d1=%h want 1/deadbeef", out_valid, read_data1);
    end
  endtask

  task automatic test_imm();
    idle();
    in_valid = 1; instr = mk_i(6'h0D, 1, 2, 16'h8001);
    tick();
    n_vec++;
    if (imm_ext !== 32'h0000_8001 || opcode !== 6'h0D) begin
      n_err++; $display("FAIL imm_ori: got imm=%h op=%h want 00008001/0d", imm_ext, opcode);
    end
    instr = mk_i(6'h08, 1, 2, 16'h8001);
    tick();
    idle();
    n_vec++;
    if (imm_ext !== 32'hFFFF_8001 || opcode !== 6'h08) begin
      n_err++; $display("FAIL imm_addi: got imm=%h op=%h want ffff8001/08", imm_ext, opcode);
    end
    tick();
  endtask

  task automatic test_hazard();
    idle();
    in_valid = 1; instr = mk_r(1, 3, 4); ex_memread = 1; ex_rt = 3;
    #1;
    n_vec++;
    if (stall !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL hazard_detect: got stall=%0b in_ready=%0b want 1/0", stall, in_ready);
    end
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL hazard_bubble: got %0b want 0", out_valid); end
    ex_memread = 0;
    #1;
    n_vec++;
    if (stall !== 1'b0 || in_ready !== 1'b1) begin
      n_err++; $display("FAIL hazard_clear: got stall=%0b in_ready=%0b want 0/1", stall, in_ready);
    end
    tick();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || rt !== 5'd3 || rs !== 5'd1) begin
      n_err++; $display("FAIL hazard_accept: got valid=%0b rs=%0d rt=%0d want 1/1/3", out_valid, rs, rt);
    end
    tick();
  endtask

  task automatic test_hold_refresh_flush();
    idle();
    wb_en = 1; wb_reg = 2; wb_data = 32'h11;
    tick();
    wb_reg = 4; wb_data = 32'h22;
    tick();
    idle();
    in_valid = 1; instr = mk_r(2, 4, 6); out_ready = 0;
    tick();
    instr = mk_r(1, 1, 1);
    wb_en = 1; wb_reg = 2; wb_data = 32'hAAAA_0001;
    #1;
    n_vec++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold_in_ready: got %0b want 0", in_ready); end
    tick();
    n_vec++;
    if (read_data1 !== 32'hAAAA_0001 || read_data2 !== 32'h22) begin
      n_err++; $display("FAIL hold_refresh: got %h/%h want aaaa0001/00000022", read_data1, read_data2);
    end
    wb_reg = 9; wb_data = 32'h5555;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_vec++;
      if (out_valid !== 1'b1 || opcode !== 6'h00 || rs !== 5'd2 || rt !== 5'd4 || rd !== 5'd6 ||
          read_data1 !== 32'hAAAA_0001 || read_data2 !== 32'h22 || imm_ext !== 32'h3020) begin
        n_err++;
        $display("FAIL hold_stable: got v=%0b op=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h want 1/00/2/4/6/aaaa0001/22/3020",
                 out_valid, opcode, rs, rt, rd, read_data1, read_data2, imm_ext);
      end
    end
    wb_en = 0; flush = 1;
    tick();
    n_vec++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_flush: got %0b want 0", out_valid); end
    idle();
    tick();
  endtask

  task automatic test_reset_mid_hold();
    idle();
    in_valid = 1; instr = mk_r(5, 5, 1); out_ready = 0;
    tick();
    n_vec++;
    if (out_valid !== 1'b1 || read_data1 !== 32'h0000_1234) begin
      n_err++; $display("FAIL rst_hold_setup: got valid=%0b d1=%h want 1/00001234", out_valid, read_data1);
    end
    idle();
    rst_n = 0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || read_data1 !== 32'h0) begin
      n_err++; $display("FAIL rst_mid_hold: got valid=%0b d1=%h want 0/0", out_valid, read_data1);
    end
    model_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    in_valid = 1; instr = mk_r(5, 0, 0);
    tick();
    idle();
    n_vec++;
    if (out_valid !== 1'b1 || read_data1 !== 32'h0) begin
      n_err++; $display("FAIL rst_r5_cleared: got valid=%0b d1=%h want 1/0", out_valid, read_data1);
    end
    tick();
  endtask

  task automatic test_random();
    logic [5:0] ops [6];
    logic [5:0] op;
    ops = '{6'h00, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h08};
    for (int cyc = 0; cyc < 600; cyc++) begin
      op = ($urandom_range(0, 7) == 0) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      in_valid   = ($urandom_range(0, 9) < 7);
      instr      = mk_i(op, $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom));
      wb_en      = $urandom_range(0, 1);
      wb_reg     = 5'($urandom_range(0, 7));
      wb_data    = $urandom;
      ex_memread = ($urandom_range(0, 3) == 0);
      ex_rt      = 5'($urandom_range(0, 3));
      flush      = ($urandom_range(0, 15) == 0);
      out_ready  = ($urandom_range(0, 9) < 6);
      #1;
      n_vec++;
      if (in_ready !== exp_ready() || stall !== exp_hazard()) begin
        n_err++;
        $display("FAIL rand_hs[%0d]: got in_ready=%0b stall=%0b want %0b/%0b",
                 cyc, in_ready, stall, exp_ready(), exp_hazard());
      end
      tick();
      n_vec++;
      if (out_valid !== m_valid) begin
        n_err++; $display("FAIL rand_valid[%0d]: got %0b want %0b", cyc, out_valid, m_valid);
      end else if (m_valid && (opcode !== m_op || rs !== m_rs || rt !== m_rt || rd !== m_rd ||
                   read_data1 !== m_rd1 || read_data2 !== m_rd2 || imm_ext !== m_imm)) begin
        n_err++;
        $display("FAIL rand_fields[%0d]: got op=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h want op=%h rs=%0d rt=%0d rd=%0d d1=%h d2=%h imm=%h",
                 cyc, opcode, rs, rt, rd, read_data1, read_data2, imm_ext,
                 m_op, m_rs, m_rt, m_rd, m_rd1, m_rd2, m_imm);
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_read_r5();
    test_bypass();
    test_imm();
    test_hazard();
    test_hold_refresh_flush();
    test_reset_mid_hold();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter DATA_W, default 32: register and operand width; SHALL be at least 16.
REQ-002 Parameter NREGS, default 32: register count; address width AW = clog2(NREGS), at most 5.
REQ-003 Parameter HAZARD_EN, default 1: 1 enables load-use stall detection; 0 disables it.
REQ-004 CLK  in  1  single clock; all state updates on the rising edge.
REQ-005 RST_N  in  1  reset, asynchronous, active-low.
REQ-006 in_valid  in  1  instr is valid this cycle.
REQ-007 in_ready  out  1  stage accepts instr this cycle.
REQ-008 instr  in  32  fetched instruction.
REQ-009 wb_en  in  1  writeback write enable.
REQ-010 wb_reg  in  AW  writeback destination register.
REQ-011 wb_data  in  DATA_W  writeback data.
REQ-012 ex_memread  in  1  instruction in EX is a load.
REQ-013 ex_rt  in  AW  destination register of that load.
REQ-014 flush  in  1  squash the stage contents.
REQ-015 out_valid  out  1  decoded outputs are valid.
REQ-016 out_ready  in  1  downstream accepts the outputs.
REQ-017 opcode  out  6  instr[31:26], registered.
REQ-018 rs, rt, rd  out  AW each  instr[25:21], instr[20:16] and instr[15:11], each truncated to AW bits and registered.
REQ-019 read_data1, read_data2  out  DATA_W each  registered operands for rs and rt.
REQ-020 imm_ext  out  DATA_W  registered extended instr[15:0].
REQ-021 stall  out  1  load-use bubble is being inserted this cycle.

Function
REQ-022 Latency: exactly one cycle from acceptance (in_valid && in_ready) to out_valid=1 with the matching fields.
REQ-023 Register reads are combinational at acceptance; their results are captured into read_data1 and read_data2.
REQ-024 Register 0 reads as 0; writes to register 0 are ignored.
REQ-025 Write-through bypass: if wb_en is high, wb_reg is nonzero and wb_reg equals the source being read, the captured value is wb_data from the same cycle.
REQ-026 Held refresh: while out_valid=1 and out_ready=0, a writeback to the held rs or rt (nonzero) updates read_data1 or read_data2 on that edge.
REQ-027 Immediate: opcodes 0x0C, 0x0D and 0x0E zero-extend; every other opcode sign-extends.
REQ-028 Load-use hazard: hazard = HAZARD_EN && ex_memread && ex_rt != 0 && (ex_rt == instr rs || ex_rt == instr rt), evaluated only when in_valid=1.
REQ-029 On hazard:
- stall=1 and in_ready=0;
- next cycle out_valid=0 (bubble), provided downstream can take it.
REQ-030 in_ready = !hazard && (!out_valid || out_ready).
REQ-031 Output register update, highest priority first:
- flush=1 → out_valid=0, and in_ready is ignored that cycle;
- accept → load new fields, out_valid=1;
- out_ready=1 → out_valid=0;
- otherwise hold.
REQ-032 While out_valid=1 and out_ready=0, all outputs SHALL be stable, except for the refresh in REQ-026.
REQ-033 The register-file write occurs on the edge even when flush or stall is active.

Reset
REQ-034 When RST_N is low, immediately:
- out_valid=0, stall=0;
- opcode, rs, rt, rd, read_data1, read_data2 and imm_ext are 0;
- all registers are 0.
REQ-035 Reset mid-transfer discards the held instruction; the first acceptance after release behaves as after power-up.

Structure
REQ-036 Shared package contents: opcode constants (ANDI=0x0C, ORI=0x0D, XORI=0x0E, LW=0x23) and the AW derivation function.
REQ-037 Sub-module regfile_2r1w (parameters DATA_W and NREGS):
- two asynchronous reads, one synchronous write;
- write-through bypass inside;
- asynchronous active-low clear.
REQ-038 Extension and hazard logic stay inline; the estimated size is 150-250 lines.

Verification
REQ-039 Write r5=0x0000_1234, then decode ADD with rs=5 and rt=0 → read_data1=0x1234, read_data2=0, out_valid one cycle later.
REQ-040 Same-cycle wb_en, wb_reg=7, wb_data=0xDEAD_BEEF while instr rs=7 is accepted → read_data1=0xDEADBEEF.
REQ-041 ORI with imm 0x8001 → imm_ext=0x0000_8001; ADDI with imm 0x8001 → imm_ext=0xFFFF_8001.
REQ-042 ex_memread=1, ex_rt=3, instr rt=3 → stall=1, in_ready=0, one bubble (out_valid=0), then the instruction is accepted the next cycle.
REQ-043 out_ready=0 for 3 cycles with a valid output, while wb writes the held rs → outputs are stable except that read_data1 is updated; flush during the hold → out_valid=0 next cycle.
REQ-044 RST_N asserted low mid-hold → out_valid drops to 0 immediately; after release, a read of r5 returns 0.
